// File: rtl/writeback_arbiter_pkg.sv
// writeback_arbiter_pkg
// Shared definitions for the register-file writeback arbiter:
//   - register address width and the hard-wired zero register (x0)
//   - port-count limits and a configuration check function used as an
//     elaboration-time guard by the top level
//   - status/report formatting helpers (simulation only)
// Optional feature macro referenced by users of this package: WB_ARB_STATS_EN
package writeback_arbiter_pkg;

  localparam int REG_ADDR_W = 5;
  localparam logic [REG_ADDR_W-1:0] REG_X0 = '0;

  localparam int MIN_PORTS = 2;
  localparam int MAX_PORTS = 8;

  // True when the port count is in range and the pointer is wide enough
  // to index every port.
  function automatic bit ports_cfg_ok(input int num_ports, input int ptr_w);
    return (num_ports >= MIN_PORTS) && (num_ports <= MAX_PORTS) &&
           ((1 << ptr_w) >= num_ports);
  endfunction

`ifndef SYNTHESIS
  function automatic string fmt_status(input int core, input logic [31:0] cycle,
                                       input logic [MAX_PORTS-1:0] valid,
                                       input logic [MAX_PORTS-1:0] ready,
                                       input int ptr, input logic wr_en,
                                       input logic [REG_ADDR_W-1:0] wr_reg);
    return $sformatf("[wb_arb core %0d] cycle=%0d req_valid=%0h req_ready=%0h rr_ptr=%0d write=%0b write_reg=%0d",
                     core, cycle, valid, ready, ptr, wr_en, wr_reg);
  endfunction

  function automatic string fmt_grant(input int core, input int port,
                                      input logic [31:0] count);
    return $sformatf("[wb_arb core %0d]   grant_count[%0d]=%0d", core, port, count);
  endfunction

  function automatic string fmt_conflict(input int core, input logic [31:0] count);
    return $sformatf("[wb_arb core %0d]   conflict_count=%0d", core, count);
  endfunction
`endif

endpackage

// File: rtl/writeback_arbiter_select.sv
// rr_priority_select
// Combinational round-robin picker: returns the first set bit of req,
// searching upward from ptr and wrapping modulo N.
// Ports:
//   req   in  [N-1:0]      request vector
//   ptr   in  [IDX_W-1:0]  search start position (expected < N)
//   grant out [N-1:0]      one-hot winner (all zero when nothing requested)
//   idx   out [IDX_W-1:0]  binary index of the winner (0 when none)
//   any   out              at least one request present
// Kept independent of the writeback datapath so other arbiters can reuse it.
module rr_priority_select #(
  parameter int N     = 2,
  parameter int IDX_W = 3
) (
  input  logic [N-1:0]     req,
  input  logic [IDX_W-1:0] ptr,
  output logic [N-1:0]     grant,
  output logic [IDX_W-1:0] idx,
  output logic             any
);

  // Priority offset k is examined before k+1; the inner loop finds the port
  // sitting at offset k from ptr. Both loops unroll to constant indices.
  always_comb begin
    grant = '0;
    idx   = '0;
    any   = 1'b0;
    for (int k = 0; k < N; k++) begin
      for (int i = 0; i < N; i++) begin
        if (!any && req[i] && (((int'(ptr) + k) % N) == i)) begin
          any      = 1'b1;
          grant[i] = 1'b1;
          idx      = IDX_W'(i);
        end
      end
    end
  end

endmodule

// File: rtl/writeback_arbiter.sv
// writeback_arbiter
// Shares the single register-file write port between NUM_PORTS writeback
// sources using valid/ready handshakes and a round-robin scheduler. The
// accepted request is registered onto write/write_reg/write_data one cycle
// after acceptance. Writes to x0 are accepted and consumed but never enable
// the register-file write.
// Ports:
//   clock       in   clock, all state on posedge
//   reset       in   asynchronous active-high reset
//   stall       in   blocks all acceptance while high
//   req_valid   in   [NUM_PORTS]             per-port request
//   req_reg     in   [NUM_PORTS*5]           port i at [5i+4:5i]
//   req_data    in   [NUM_PORTS*DATA_WIDTH]  port i at [DATA_WIDTH*i +: DATA_WIDTH]
//   req_ready   out  [NUM_PORTS]             one-hot accept
//   write       out  register-file write enable
//   write_reg   out  [5]  register-file destination
//   write_data  out  [DATA_WIDTH]  register-file data
//   report      in   print a status block this cycle (simulation only)
// Optional feature: define WB_ARB_STATS_EN to add per-port grant counters
// and a conflict counter, printed with the status block.
module writeback_arbiter
  import writeback_arbiter_pkg::*;
#(
  parameter int CORE       = 0,
  parameter int DATA_WIDTH = 32,
  parameter int NUM_PORTS  = 2,
  parameter int PTR_W      = 3
) (
  input  logic                            clock,
  input  logic                            reset,
  input  logic                            stall,
  input  logic [NUM_PORTS-1:0]            req_valid,
  input  logic [NUM_PORTS*REG_ADDR_W-1:0] req_reg,
  input  logic [NUM_PORTS*DATA_WIDTH-1:0] req_data,
  output logic [NUM_PORTS-1:0]            req_ready,
  output logic                            write,
  output logic [REG_ADDR_W-1:0]           write_reg,
  output logic [DATA_WIDTH-1:0]           write_data,
  input  logic                            report
);

  localparam bit CFG_OK = ports_cfg_ok(NUM_PORTS, PTR_W);

  generate
    if (!CFG_OK) begin : g_cfg_error
      $error("writeback_arbiter: NUM_PORTS must be 2..8 and fit in PTR_W bits");
    end
  endgenerate

  logic [PTR_W-1:0]      rr_ptr;
  logic [31:0]           cycles;
  logic [NUM_PORTS-1:0]  grant;
  logic [PTR_W-1:0]      grant_idx;
  logic                  grant_any;
  logic                  accept;
  logic [PTR_W-1:0]      rr_ptr_next;
  logic [REG_ADDR_W-1:0] sel_reg;
  logic [DATA_WIDTH-1:0] sel_data;

  rr_priority_select #(
    .N     (NUM_PORTS),
    .IDX_W (PTR_W)
  ) u_select (
    .req   (req_valid),
    .ptr   (rr_ptr),
    .grant (grant),
    .idx   (grant_idx),
    .any   (grant_any)
  );

  // Ready is suppressed during reset as well as stall so nothing can be
  // considered handed over while state is being cleared.
  assign req_ready = (stall || reset) ? '0 : grant;
  assign accept    = grant_any && !stall && !reset;

  assign rr_ptr_next = (grant_idx == PTR_W'(NUM_PORTS - 1)) ? '0
                                                             : grant_idx + PTR_W'(1);

  // One-hot AND-OR mux of the granted port's payload.
  always_comb begin
    sel_reg  = '0;
    sel_data = '0;
    for (int i = 0; i < NUM_PORTS; i++) begin
      if (grant[i]) begin
        sel_reg  = sel_reg  | req_reg[REG_ADDR_W*i +: REG_ADDR_W];
        sel_data = sel_data | req_data[DATA_WIDTH*i +: DATA_WIDTH];
      end
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      write      <= 1'b0;
      write_reg  <= '0;
      write_data <= '0;
      rr_ptr     <= '0;
      cycles     <= '0;
    end else begin
      cycles <= cycles + 32'd1;
      if (accept) begin
        // x0 is consumed here but never enables the register-file write.
        write      <= (sel_reg != REG_X0);
        write_reg  <= sel_reg;
        write_data <= sel_data;
        rr_ptr     <= rr_ptr_next;
      end else begin
        write <= 1'b0;
      end
    end
  end

`ifdef WB_ARB_STATS_EN
  logic [31:0] grant_count [NUM_PORTS];
  logic [31:0] conflict_count;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_PORTS; gi++) begin : g_grant_cnt
      always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
          grant_count[gi] <= '0;
        end else if (accept && grant[gi]) begin
          grant_count[gi] <= grant_count[gi] + 32'd1;
        end
      end
    end
  endgenerate

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      conflict_count <= '0;
    end else if (!stall && ($countones(req_valid) >= 2)) begin
      conflict_count <= conflict_count + 32'd1;
    end
  end
`endif

`ifndef SYNTHESIS
  always @(posedge clock) begin
    if (report && !reset) begin
      $display("%s write_data=%0h",
               fmt_status(CORE, cycles, MAX_PORTS'(req_valid), MAX_PORTS'(req_ready),
                          int'(rr_ptr), write, write_reg),
               write_data);
`ifdef WB_ARB_STATS_EN
      for (int i = 0; i < NUM_PORTS; i++) begin
        $display("%s", fmt_grant(CORE, i, grant_count[i]));
      end
      $display("%s", fmt_conflict(CORE, conflict_count));
`endif
    end
  end
`endif

endmodule

// File: tb/tb_writeback_arbiter.sv
// tb_writeback_arbiter
// Self-checking bench for writeback_arbiter (NUM_PORTS=2, DATA_WIDTH=32):
// a directed vector table, hand-written reset/stats sequences, and a
// randomized run checked against a request-level reference model.
module tb_writeback_arbiter;

  localparam int N  = 2;
  localparam int DW = 32;

  logic            clock = 1'b0;
  logic            reset;
  logic            stall;
  logic            report;
  logic [N-1:0]    req_valid;
  logic [N*5-1:0]  req_reg;
  logic [N*DW-1:0] req_data;
  logic [N-1:0]    req_ready;
  logic            write;
  logic [4:0]      write_reg;
  logic [DW-1:0]   write_data;

  int checks   = 0;
  int failures = 0;

  writeback_arbiter #(
    .CORE       (0),
    .DATA_WIDTH (DW),
    .NUM_PORTS  (N),
    .PTR_W      (3)
  ) dut (
    .clock      (clock),
    .reset      (reset),
    .stall      (stall),
    .req_valid  (req_valid),
    .req_reg    (req_reg),
    .req_data   (req_data),
    .req_ready  (req_ready),
    .write      (write),
    .write_reg  (write_reg),
    .write_data (write_data),
    .report     (report)
  );

  always #5 clock = ~clock;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  // Called at a negedge: drive inputs, sample ready and the pre-edge write,
  // then return at the next negedge (one posedge later).
  task automatic apply(input logic st, input logic [N-1:0] v,
                       input logic [4:0] r0, input logic [4:0] r1,
                       input logic [DW-1:0] d0, input logic [DW-1:0] d1,
                       output logic [N-1:0] rdy, output logic w_pre);
    stall     = st;
    req_valid = v;
    req_reg   = {r1, r0};
    req_data  = {d1, d0};
    #1;
    rdy   = req_ready;
    w_pre = write;
    @(negedge clock);
  endtask

  task automatic do_reset();
    reset = 1'b1; stall = 1'b0; req_valid = '0; req_reg = '0; req_data = '0;
    @(negedge clock);
    @(negedge clock);
    reset = 1'b0;
  endtask

  typedef struct {
    logic          st;
    logic [N-1:0]  v;
    logic [4:0]    r0, r1;
    logic [DW-1:0] d0, d1;
    logic [N-1:0]  rdy;   // expected ready before the edge
    logic          w;     // expected outputs after the edge
    logic [4:0]    wr;
    logic [DW-1:0] wd;
  } vec_t;

  localparam int NV = 16;
  vec_t tbl [NV];

  // reference model state for the random phase
  int            mptr;
  logic          pv [N];
  logic [4:0]    pr [N];
  logic [DW-1:0] pd [N];
  int            waited [N];
  logic          ew;
  logic [4:0]    ewr;
  logic [DW-1:0] ewd;

  initial begin
    logic [N-1:0] rdy;
    logic         w_pre;
    logic         prev_w;
    int           g;
    logic         st;
    logic [N-1:0] erdy;
    logic [N-1:0] vv;

    // rr_ptr starts at 0 after reset
    tbl[0]  = '{1'b0, 2'b00, 5'd0, 5'd0, 32'h0,    32'h0,        2'b00, 1'b0, 5'd0, 32'h0};
    tbl[1]  = '{1'b0, 2'b10, 5'd0, 5'd5, 32'h0,    32'hDEADBEEF, 2'b10, 1'b1, 5'd5, 32'hDEADBEEF};
    tbl[2]  = '{1'b0, 2'b00, 5'd0, 5'd0, 32'h0,    32'h0,        2'b00, 1'b0, 5'd5, 32'hDEADBEEF};
    tbl[3]  = '{1'b0, 2'b11, 5'd1, 5'd2, 32'h11,   32'h22,       2'b01, 1'b1, 5'd1, 32'h11};
    tbl[4]  = '{1'b0, 2'b11, 5'd1, 5'd2, 32'h11,   32'h22,       2'b10, 1'b1, 5'd2, 32'h22};
    tbl[5]  = '{1'b0, 2'b11, 5'd1, 5'd2, 32'h11,   32'h22,       2'b01, 1'b1, 5'd1, 32'h11};
    tbl[6]  = '{1'b0, 2'b11, 5'd1, 5'd2, 32'h11,   32'h22,       2'b10, 1'b1, 5'd2, 32'h22};
    tbl[7]  = '{1'b1, 2'b11, 5'd1, 5'd2, 32'h11,   32'h22,       2'b00, 1'b0, 5'd2, 32'h22};
    tbl[8]  = '{1'b1, 2'b11, 5'd1, 5'd2, 32'h11,   32'h22,       2'b00, 1'b0, 5'd2, 32'h22};
    tbl[9]  = '{1'b1, 2'b11, 5'd1, 5'd2, 32'h11,   32'h22,       2'b00, 1'b0, 5'd2, 32'h22};
    tbl[10] = '{1'b0, 2'b11, 5'd1, 5'd2, 32'h11,   32'h22,       2'b01, 1'b1, 5'd1, 32'h11};
    tbl[11] = '{1'b0, 2'b01, 5'd0, 5'd0, 32'h1234, 32'h0,        2'b01, 1'b0, 5'd0, 32'h1234};
    tbl[12] = '{1'b0, 2'b10, 5'd0, 5'd7, 32'h0,    32'h77,       2'b10, 1'b1, 5'd7, 32'h77};
    tbl[13] = '{1'b0, 2'b11, 5'd9, 5'd9, 32'hAA,   32'hBB,       2'b01, 1'b1, 5'd9, 32'hAA};
    tbl[14] = '{1'b0, 2'b11, 5'd9, 5'd9, 32'hAA,   32'hBB,       2'b10, 1'b1, 5'd9, 32'hBB};
    tbl[15] = '{1'b0, 2'b00, 5'd0, 5'd0, 32'h0,    32'h0,        2'b00, 1'b0, 5'd9, 32'hBB};

    report = 1'b0;
    reset  = 1'b1; stall = 1'b0; req_valid = 2'b01; req_reg = '0; req_data = '0;
    @(negedge clock);
    chk("reset_write", 64'(write), 64'd0);
    chk("reset_write_reg", 64'(write_reg), 64'd0);
    chk("reset_write_data", 64'(write_data), 64'd0);
    chk("reset_ready", 64'(req_ready), 64'd0);
    do_reset();

    // ---------------- directed table ----------------
    prev_w = 1'b0;
    for (int i = 0; i < NV; i++) begin
      report = (i == 4);
      apply(tbl[i].st, tbl[i].v, tbl[i].r0, tbl[i].r1, tbl[i].d0, tbl[i].d1, rdy, w_pre);
      $display("vec %0d: stall=%0b valid=%b ready=%b write=%0b reg=%0d data=%h",
               i, tbl[i].st, tbl[i].v, rdy, write, write_reg, write_data);
      chk($sformatf("vec%0d_ready", i), 64'(rdy), 64'(tbl[i].rdy));
      chk($sformatf("vec%0d_write_pre_edge", i), 64'(w_pre), 64'(prev_w));
      chk($sformatf("vec%0d_write", i), 64'(write), 64'(tbl[i].w));
      chk($sformatf("vec%0d_write_reg", i), 64'(write_reg), 64'(tbl[i].wr));
      chk($sformatf("vec%0d_write_data", i), 64'(write_data), 64'(tbl[i].wd));
      prev_w = tbl[i].w;
    end
    report = 1'b0;

    // ---------------- asynchronous reset mid-transfer ----------------
    do_reset();
    apply(1'b0, 2'b01, 5'd3, 5'd0, 32'h33, 32'h0, rdy, w_pre); // port0 accepted, ptr -> 1
    chk("rst_seq_write_before", 64'(write), 64'd1);
    req_valid = 2'b11; req_reg = {5'd8, 5'd6}; req_data = {32'h88, 32'h66};
    #2;
    reset = 1'b1;
    #1;
    $display("async reset: write=%0b reg=%0d data=%h ready=%b", write, write_reg, write_data, req_ready);
    chk("rst_async_write", 64'(write), 64'd0);
    chk("rst_async_write_reg", 64'(write_reg), 64'd0);
    chk("rst_async_write_data", 64'(write_data), 64'd0);
    chk("rst_async_ready", 64'(req_ready), 64'd0);
    @(negedge clock);
    reset = 1'b0;
    #1;
    chk("rst_first_grant", 64'(req_ready), 64'b01);
    @(negedge clock);
    chk("rst_first_write_reg", 64'(write_reg), 64'd6);
    chk("rst_first_write_data", 64'(write_data), 64'h66);

    // ---------------- randomized run vs reference model ----------------
    do_reset();
    mptr = 0; ew = 1'b0; ewr = '0; ewd = '0;
    for (int p = 0; p < N; p++) begin
      pv[p] = 1'b0; pr[p] = '0; pd[p] = '0; waited[p] = 0;
    end
    for (int c = 0; c < 600; c++) begin
      for (int p = 0; p < N; p++) begin
        if (!pv[p] && $urandom_range(0, 1) == 1) begin
          pv[p] = 1'b1;
          pr[p] = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
          pd[p] = $urandom;
        end
      end
      st = ($urandom_range(0, 4) == 0);
      g = -1;
      for (int k = 0; k < N; k++) begin
        if (g < 0 && pv[(mptr + k) % N]) g = (mptr + k) % N;
      end
      erdy = (st || g < 0) ? '0 : N'(1 << g);
      for (int p = 0; p < N; p++) vv[p] = pv[p];
      apply(st, vv, pr[0], pr[1], pd[0], pd[1], rdy, w_pre);
      $display("rand %0d: stall=%0b valid=%b ready=%b exp_ready=%b write=%0b reg=%0d data=%h",
               c, st, vv, rdy, erdy, write, write_reg, write_data);
      chk("rand_ready", 64'(rdy), 64'(erdy));
      chk("rand_write_pre_edge", 64'(w_pre), 64'(ew));
      if (erdy != '0) begin
        ew  = (pr[g] != 5'd0);
        ewr = pr[g];
        ewd = pd[g];
        mptr = (g + 1) % N;
        chk("rand_fairness_wait_ok", 64'(waited[g] <= N - 1), 64'd1);
        pv[g] = 1'b0;
        waited[g] = 0;
      end else begin
        ew = 1'b0;
      end
      for (int p = 0; p < N; p++) begin
        if (pv[p] && !st) waited[p]++;
      end
      chk("rand_write", 64'(write), 64'(ew));
      chk("rand_write_reg", 64'(write_reg), 64'(ewr));
      chk("rand_write_data", 64'(write_data), 64'(ewd));
    end

`ifdef WB_ARB_STATS_EN
    // ---------------- statistics counters ----------------
    do_reset();
    for (int i = 0; i < 4; i++) begin
      apply(1'b0, 2'b11, 5'd1, 5'd2, 32'h11, 32'h22, rdy, w_pre);
      chk("stats_rr_ready", 64'(rdy), (i % 2 == 0) ? 64'b01 : 64'b10);
    end
    apply(1'b0, 2'b00, 5'd0, 5'd0, 32'h0, 32'h0, rdy, w_pre);
    $display("stats: grant0=%0d grant1=%0d conflict=%0d",
             dut.grant_count[0], dut.grant_count[1], dut.conflict_count);
    chk("stats_grant0", 64'(dut.grant_count[0]), 64'd2);
    chk("stats_grant1", 64'(dut.grant_count[1]), 64'd2);
    chk("stats_conflict", 64'(dut.conflict_count), 64'd4);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Global watchdog so the run always terminates.
  initial begin
    #200000;
    $display("FAIL watchdog timeout actual=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
